tia_write_strobe_sequencer: RTL
===============================

# tia_write_strobe_sequencer

Registered, parametrised successor to the combinational TIA write-address decode. Samples CPU writes on the `phi2` rising edge and emits one-cycle, one-hot write strobes to the TIA register file. Adds three behaviours the flat decode lacks: per-address deferred strobes (HMOVE-style late effects), a WSYNC halt that drives CPU `rdy`, and an unmapped-address flag. Sits between the CPU bus interface and every TIA register/strobe consumer.

## Interface
Parameters:
- `ADDR_W`, 6, write address width
- `NUM_REGS`, 45, number of strobe outputs; addresses `0..NUM_REGS-1` are mapped, and `NUM_REGS` is at most `2**ADDR_W`
- `DEFER_MASK`, `64'h0000_0400_0000_0000` (bit 42, HMOVE), a set bit marks that address as deferred; only bits below `2**ADDR_W` are used
- `DEFER_CYCLES`, 2, extra delay applied to deferred strobes; at least 1
- `WSYNC_ADDR`, 2, address that triggers the WSYNC halt

Ports:
- `phi2`  in  1  clock; all state updates on the rising edge
- `reset_bar`  in  1  reset, synchronous, active-low
- `a`  in  ADDR_W  write address
- `w_bar`  in  1  write enable, active-low
- `cs_bar`  in  1  TIA chip select, active-low
- `hsync_pulse`  in  1  one-cycle pulse at start of line; releases WSYNC
- `strobe`  out  NUM_REGS  one-hot write strobes, registered
- `rdy`  out  1  CPU ready; low halts the CPU
- `bad_addr`  out  1  one-cycle pulse for an unmapped write
- `defer_busy`  out  1  a deferred strobe is pending
- `defer_drop`  out  1  one-cycle pulse when a pending deferred strobe is overwritten

## Operation
- **Accept.** A write is accepted on a rising edge where `reset_bar`=1, `w_bar`=0 and `cs_bar`=0. The address is captured in that cycle.
- **Immediate strobe.** For a mapped, non-deferred address A, `strobe[A]`=1 for exactly the next cycle. All other bits stay 0.
- **Unmapped address.** For A ≥ `NUM_REGS` there is no strobe, and `bad_addr`=1 for the next cycle.
- **Deferred strobe.** For a mapped A with `DEFER_MASK[A]`=1:
  - load the single defer slot with A and a counter of `DEFER_CYCLES`; `defer_busy`=1.
  - decrement the counter each cycle.
  - `strobe[A]` fires for one cycle when the counter expires; `defer_busy` clears in that same cycle.
- **Defer-slot collision.** A deferred write accepted while `defer_busy`=1:
  - replaces the slot address and restarts the counter.
  - the old strobe never fires.
  - `defer_drop`=1 for one cycle.
- **Simultaneous strobes.** A deferred strobe and an immediate strobe landing in the same cycle produce both bits set; this is the only case where `strobe` is not one-hot. If both target the same bit, it is a single pulse.
- **WSYNC state machine** (states RUN and HALT):
  - RUN → HALT on acceptance of a write to `WSYNC_ADDR`. `rdy`=0 from the following cycle, the same cycle as `strobe[WSYNC_ADDR]`.
  - HALT → RUN on the first `hsync_pulse`=1 sampled in HALT. `rdy`=1 from the next cycle.
  - `hsync_pulse` in the acceptance cycle itself is ignored, so `rdy` is low for at least one cycle.
  - A further WSYNC write during HALT still strobes but does not change state.
- **Writes while halted.** Writes are still accepted while `rdy`=0; RDY gating of the CPU is the CPU's concern.
- **Reset** (`reset_bar`=0 at an edge): `strobe`=0, `rdy`=1, `bad_addr`=0, `defer_busy`=0, `defer_drop`=0, state RUN, defer slot cleared. Reset mid-deferral or mid-HALT discards the pending strobe or halt. No write is accepted in a reset cycle.

## Timing
- Accept at edge n → immediate strobe / `bad_addr` high during cycle n+1.
- Deferred strobe high during cycle n+1+`DEFER_CYCLES`.
- `defer_busy` high during cycles n+1 through n+`DEFER_CYCLES`.
- Counter width is `$clog2(DEFER_CYCLES+1)`.
- WSYNC accepted at n → `rdy`=0 from n+1. `hsync_pulse` sampled at edge m > n → `rdy`=1 from m+1.
- Back-to-back writes on consecutive edges each produce a strobe on consecutive cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `TIA_WRITE_STROBE_WSYNC_EN`.
- Defined: the WSYNC state machine is present, as described above.
- Undefined:
  - no state machine is built, and `rdy` is constant 1.
  - `hsync_pulse` is unused.
  - `WSYNC_ADDR` is an ordinary immediate strobe.

## Test plan
- **Immediate strobe.** Reset, then write A=6'h06 at edge 3 → `strobe`=45'h40 during cycle 4 only, all other outputs 0.
- **Unmapped address.** Write A=6'h3f → no strobe bit set; `bad_addr`=1 for one cycle.
- **Deferral with overlap.** Write 6'h2a, then 6'h10 at the next edge → `strobe[16]` at +1 relative to its own write; `strobe[42]` at +3 relative to the 2a write; `defer_busy` high for 2 cycles.
- **Defer collision.** Write 6'h2a twice, one cycle apart → one `strobe[42]` only, 3 cycles after the second write; `defer_drop`=1 once.
- **WSYNC halt.** Write 6'h02 at edge 10, hold `hsync_pulse`=1 at edge 10 and again at edge 15 → `rdy`=0 during cycles 11–15, 1 from cycle 16. With the macro undefined → `rdy` stays 1.
- **Reset mid-operation.** Assert `reset_bar`=0 during a pending deferral and HALT → next cycle all outputs at reset values; no late strobe ever appears.

Source files
------------

// File: rtl/tia_write_strobe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tia_write_strobe_sequencer
//  Brief    : Registered TIA write-address decode. Produces one-cycle one-hot
//             write strobes, per-address deferred strobes (single defer slot),
//             an unmapped-address pulse and an optional WSYNC halt on rdy.
//             The WSYNC state machine is built only when the macro
//             TIA_WRITE_STROBE_WSYNC_EN is defined; otherwise rdy is tied 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tia_write_strobe_sequencer #(
    parameter int          ADDR_W       = 6,
    parameter int          NUM_REGS     = 45,
    parameter logic [63:0] DEFER_MASK   = 64'h0000_0400_0000_0000,
    parameter int          DEFER_CYCLES = 2,
    parameter int          WSYNC_ADDR   = 2
) (
    input  logic                phi2,
    input  logic                reset_bar,
    input  logic [ADDR_W-1:0]   a,
    input  logic                w_bar,
    input  logic                cs_bar,
    input  logic                hsync_pulse,
    output logic [NUM_REGS-1:0] strobe,
    output logic                rdy,
    output logic                bad_addr,
    output logic                defer_busy,
    output logic                defer_drop
);

    localparam int                  CNT_W     = $clog2(DEFER_CYCLES + 1);
    localparam logic [NUM_REGS-1:0] DEFER_VEC = NUM_REGS'(DEFER_MASK);

    logic                accept;
    logic                mapped;
    logic                def_load;
    logic                fire;
    logic [NUM_REGS-1:0] addr_dec;
    logic [NUM_REGS-1:0] imm_vec;
    logic [NUM_REGS-1:0] slot_vec;
    logic [CNT_W-1:0]    cnt;

    assign accept = ~w_bar & ~cs_bar;

    // One-hot decode of the write address over the mapped range only.
    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) addr_dec[i] = 1'b1;
        end
    end

    assign mapped   = |addr_dec;
    assign def_load = accept & (|(addr_dec & DEFER_VEC));
    assign imm_vec  = accept ? (addr_dec & ~DEFER_VEC) : '0;
    // A new deferred write takes the slot even on the expiry edge, so the
    // old strobe is dropped rather than fired.
    assign fire     = defer_busy & (cnt == CNT_W'(1)) & ~def_load;

    // Single defer slot: load/replace on a deferred write, count down otherwise.
    always_ff @(posedge phi2) begin
        if (!reset_bar) begin
            slot_vec   <= '0;
            cnt        <= '0;
            defer_busy <= 1'b0;
            defer_drop <= 1'b0;
        end else begin
            defer_drop <= def_load & defer_busy;
            if (def_load) begin
                slot_vec   <= addr_dec;
                cnt        <= CNT_W'(DEFER_CYCLES);
                defer_busy <= 1'b1;
            end else if (defer_busy) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    defer_busy <= 1'b0;
                    slot_vec   <= '0;
                end
            end
        end
    end

    // Registered strobe and unmapped-address outputs.
    always_ff @(posedge phi2) begin
        if (!reset_bar) begin
            strobe   <= '0;
            bad_addr <= 1'b0;
        end else begin
            strobe   <= imm_vec | (fire ? slot_vec : '0);
            bad_addr <= accept & ~mapped;
        end
    end

`ifdef TIA_WRITE_STROBE_WSYNC_EN
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } wsync_state_t;

    wsync_state_t state;
    wsync_state_t state_next;
    logic         wsync_hit;

    assign wsync_hit = accept & (a == ADDR_W'(WSYNC_ADDR));

    // WSYNC state register.
    always_ff @(posedge phi2) begin
        if (!reset_bar) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halt on a WSYNC write; release on the first hsync pulse seen while halted.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (wsync_hit)   state_next = HALT;
            HALT:    if (hsync_pulse) state_next = RUN;
            default:                  state_next = RUN;
        endcase
    end

    assign rdy = (state == RUN);
`else
    logic unused_hsync;
    assign unused_hsync = hsync_pulse;
    assign rdy          = 1'b1;
`endif

endmodule
`default_nettype wire
